mem_access_unit: RTL and testbench
==================================

# mem_access_unit

MEM-stage load/store unit for the pipelined MIPS core. It sits between the EX/MEM pipeline register and the byte-addressed, big-endian data memory, which has word-wide read/write ports. The unit converts LB/LBU/LH/LHU/LW/SB/SH/SW requests into word accesses, performing a two-cycle read-modify-write for sub-word stores. It registers sign- or zero-extended load results toward the writeback stage.

## Interface
Parameters:
- `ADDR_W`, 32: address width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: EX/MEM holds a memory operation.
- `req_rd` in 1: operation is a load.
- `req_wr` in 1: operation is a store.
- `req_size` in 2: access size; 00 = byte, 01 = half, 10 = word, 11 = word.
- `req_unsigned` in 1: zero-extend the load result (LBU/LHU).
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 32: store data, right-aligned (rt).
- `req_ready` out 1: request completes this cycle. Pipeline stall = `req_valid & ~req_ready`.
- `mem_addr` out ADDR_W: word-aligned address, `{req_addr[ADDR_W-1:2],2'b00}`.
- `mem_read` out 1: memory read enable.
- `mem_write` out 1: memory write enable; the memory captures on the rising edge.
- `mem_wdata` out 32: full word to write.
- `mem_rdata` in 32: combinational read data, valid in the same cycle.
- `wb_valid` out 1: registered load result valid.
- `wb_data` out 32: registered load result.
- `align_err` out 1: registered one-cycle misalignment pulse.

## Operation
- Byte lanes are big-endian. Byte offset k (`addr[1:0]`) maps to `mem_rdata[31-8k -: 8]`. Half offset 0 maps to [31:16]; half offset 2 maps to [15:0].
- States: IDLE, RMW_WR.
- IDLE behaviour by request type:
  - Load: `mem_read`=1. The unit extracts the lane, sign-extends (or zero-extends if `req_unsigned`), and registers it into `wb_data` with `wb_valid`=1. `req_ready`=1. Stays in IDLE.
  - SW: `mem_write`=1, `mem_wdata`=`req_wdata`, `req_ready`=1. Stays in IDLE.
  - SB/SH: `mem_read`=1. The unit latches the read word with the store lane replaced by `req_wdata[7:0]` / `[15:0]` into the merge register, latches the word address, and sets `req_ready`=0. Next state is RMW_WR.
- RMW_WR: `mem_write`=1, `mem_addr`=latched address, `mem_wdata`=merge register, `req_ready`=1. Next state is IDLE. The inputs are not re-sampled.
- When `req_rd` and `req_wr` are both set, the store is performed and the load is ignored.
- When `req_valid`=0 or neither rd/wr is set: no memory enables, `req_ready`=1, `wb_valid` goes to 0 next cycle.
- `wb_valid` is 1 only on the cycle after an accepted load. `wb_data` holds its last value otherwise.

## Timing
- Load latency is one cycle: accepted at edge N, `wb_data` is valid after edge N.
- SW: one cycle, no stall.
- SB/SH: two cycles, one stall cycle.
- Back-to-back requests are supported. A new request may be accepted in the cycle after `req_ready`.
- Reset values: state IDLE; `wb_valid`=0, `wb_data`=0, `align_err`=0, merge register 0.
- While `rst_n`=0: `mem_read`=`mem_write`=`req_ready`=0.
- Reset asserted in RMW_WR: the unit returns to IDLE immediately and issues no write. The store is dropped, and the pipeline is reset alongside.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - Trigger: half access with `addr[0]`=1, or word access with `addr[1:0]`≠0.
  - The unit issues no memory enable and asserts `req_ready`=1.
  - `align_err`=1 for exactly the next cycle.
  - `wb_valid` stays 0.
- `MEM_ALIGN_CHECK_EN` undefined:
  - Misaligned offsets are masked (half: `addr[0]`→0; word: `addr[1:0]`→00) and the access proceeds normally.
  - `align_err` is tied to 0.

## Test plan
- Reset: hold `rst_n`=0 with `req_valid`=1 (LW) → `wb_valid`=0, `wb_data`=0, `align_err`=0, `req_ready`=0, no memory enables.
- LW at 0x0, memory word 0x00430822 → `mem_read`=1, `req_ready`=1 the same cycle; `wb_data`=0x00430822 and `wb_valid`=1 next cycle, then 0.
- Memory word at 0x4 = 0x8CA40006:
  - LB 0x4 → 0xFFFFFF8C.
  - LBU 0x4 → 0x0000008C.
  - LH 0x6 → 0x00000006.
  - LHU 0x4 → 0x00008CA4.
- SB 0x1 with `req_wdata`=0x123456FF over 0x00430822:
  - Cycle 0: `mem_read`=1, `req_ready`=0.
  - Cycle 1: `mem_write`=1, `mem_addr`=0x0, `mem_wdata`=0x00FF0822, `req_ready`=1.
  - Then the LW at 0x0 that follows → 0x00FF0822.
- SH 0x3 (or LW 0x2):
  - With macro → no `mem_write`, `req_ready`=1, `align_err` pulses one cycle.
  - Without macro → SH writes lane [15:0] of word 0x0, `align_err`=0.
- SH 0x2 with `rst_n` asserted during RMW_WR → no `mem_write` that cycle. After release, state is IDLE and the memory word is unchanged.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit for the pipelined MIPS core.
// Converts byte/half/word loads and stores into word accesses on a
// big-endian, word-wide data memory. Sub-word stores use a two-cycle
// read-modify-write (IDLE -> RMW_WR). Load results are extended and
// registered toward writeback.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject misaligned half/word
// accesses with a one-cycle align_err pulse. Without it, misaligned offsets
// are masked down to the natural alignment.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    output logic [31:0]       wb_data,
    output logic              align_err
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_RMW_WR = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       merge_q, merge_d;
    logic              wb_valid_q, wb_valid_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic              align_err_q, align_err_d;

    logic              is_half, is_word;
    logic              misalign, do_store, do_load, reject;
    logic [1:0]        off;
    logic [ADDR_W-1:0] word_addr;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_val;
    logic [31:0]       merged;

    assign is_half   = (req_size == 2'b01);
    assign is_word   = req_size[1];
    assign word_addr = {req_addr[ADDR_W-1:2], 2'b00};

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = (is_half & req_addr[0]) | (is_word & (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Offset forced to natural alignment; only matters when the check is off.
    assign off = is_word ? 2'b00 : (is_half ? {req_addr[1], 1'b0} : req_addr[1:0]);

    // A store wins when rd and wr are both set.
    assign do_store = req_valid & req_wr & ~misalign;
    assign do_load  = req_valid & req_rd & ~req_wr & ~misalign;
    assign reject   = req_valid & (req_rd | req_wr) & misalign;

    // Big-endian lane extraction for loads and lane replacement for sub-word stores.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        rd_byte = mem_rdata[31:24];
        merged  = mem_rdata;
        case (off)
            2'd0: rd_byte = mem_rdata[31:24];
            2'd1: rd_byte = mem_rdata[23:16];
            2'd2: rd_byte = mem_rdata[15:8];
            default: rd_byte = mem_rdata[7:0];
        endcase
        rd_half = off[1] ? mem_rdata[15:0] : mem_rdata[31:16];

        if (is_word) begin
            load_val = mem_rdata;
        end else if (is_half) begin
            load_val = {{16{~req_unsigned & rd_half[15]}}, rd_half};
        end else begin
            load_val = {{24{~req_unsigned & rd_byte[7]}}, rd_byte};
        end

        if (is_half) begin
            if (off[1]) merged[15:0]  = req_wdata[15:0];
            else        merged[31:16] = req_wdata[15:0];
        end else begin
            case (off)
                2'd0: merged[31:24] = req_wdata[7:0];
                2'd1: merged[23:16] = req_wdata[7:0];
                2'd2: merged[15:8]  = req_wdata[7:0];
                default: merged[7:0] = req_wdata[7:0];
            endcase
        end
    end

    // Request sequencing: memory strobes, handshake and next-state values.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        merge_d     = merge_q;
        wb_valid_d  = 1'b0;
        wb_data_d   = wb_data_q;
        align_err_d = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        req_ready   = 1'b0;
        mem_addr    = word_addr;
        mem_wdata   = req_wdata;

        case (state_q)
            S_IDLE: begin
                req_ready   = 1'b1;
                align_err_d = reject;
                if (do_store) begin
                    if (is_word) begin
                        mem_write = 1'b1;
                    end else begin
                        mem_read  = 1'b1;
                        req_ready = 1'b0;
                        merge_d   = merged;
                        addr_d    = word_addr;
                        state_d   = S_RMW_WR;
                    end
                end else if (do_load) begin
                    mem_read   = 1'b1;
                    wb_valid_d = 1'b1;
                    wb_data_d  = load_val;
                end
            end
            S_RMW_WR: begin
                // Inputs are ignored here; the merged word was captured last cycle.
                mem_write = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = merge_q;
                req_ready = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Reset also gates the strobes, so a write pending in RMW_WR is dropped.
        if (!rst_n) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            req_ready = 1'b0;
        end
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            merge_q     <= '0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            align_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            state_q     <= state_d;
            addr_q      <= addr_d;
            merge_q     <= merge_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            align_err_q <= align_err_d;
        end
    end

    assign wb_valid  = wb_valid_q;
    assign wb_data   = wb_data_q;
    assign align_err = align_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit. A byte-array reference memory predicts load
// results and merged store words; load results go through a scoreboard queue
// that an independent monitor drains whenever wb_valid is seen.
// Follows MEM_ALIGN_CHECK_EN the same way as the design.
module tb_mem_access_unit;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_rd;
    logic              req_wr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic              mem_write;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              wb_valid;
    logic [31:0]       wb_data;
    logic              align_err;

    logic [31:0] tb_mem [0:15];
    logic [7:0]  ref_bytes [0:63];
    logic [31:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_rd(req_rd), .req_wr(req_wr),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_data(wb_data), .align_err(align_err)
    );

    always #5 clk = ~clk;

    // Data memory: combinational read, write on the rising edge.
    assign mem_rdata = tb_mem[mem_addr[5:2]];
    always @(posedge clk) if (mem_write) tb_mem[mem_addr[5:2]] <= mem_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: byte-addressed big-endian memory.
    function automatic int eff_addr(input logic [1:0] sz, input logic [5:0] a);
        if (sz == 2'b00) return int'(a);
        if (sz == 2'b01) return int'({a[5:1], 1'b0});
        return int'({a[5:2], 2'b00});
    endfunction

    function automatic logic [31:0] ref_word(input logic [5:0] a);
        int w;
        w = int'({a[5:2], 2'b00});
        return {ref_bytes[w], ref_bytes[w+1], ref_bytes[w+2], ref_bytes[w+3]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns, input logic [5:0] a);
        int e;
        logic [15:0] h;
        e = eff_addr(sz, a);
        if (sz == 2'b00) return uns ? {24'h0, ref_bytes[e]} : {{24{ref_bytes[e][7]}}, ref_bytes[e]};
        if (sz == 2'b01) begin
            h = {ref_bytes[e], ref_bytes[e+1]};
            return uns ? {16'h0, h} : {{16{h[15]}}, h};
        end
        return ref_word(a);
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [5:0] a, input logic [31:0] wd);
        int e;
        e = eff_addr(sz, a);
        if (sz == 2'b00) begin
            ref_bytes[e] = wd[7:0];
        end else if (sz == 2'b01) begin
            ref_bytes[e] = wd[15:8]; ref_bytes[e+1] = wd[7:0];
        end else begin
            ref_bytes[e] = wd[31:24]; ref_bytes[e+1] = wd[23:16];
            ref_bytes[e+2] = wd[15:8]; ref_bytes[e+3] = wd[7:0];
        end
    endtask

    function automatic bit is_mis(input logic [1:0] sz, input logic [5:0] a);
`ifdef MEM_ALIGN_CHECK_EN
        return (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
`else
        return (sz == 2'b11) && (a == 6'd0) && (sz == 2'b00);
`endif
    endfunction

    // Monitor: every wb_valid must match the oldest predicted load.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL wb_unexpected: got 0x%08h, expected no result", wb_data);
            end else begin
                check("wb_data", wb_data, exp_q.pop_front());
            end
        end
    end

    // One request starting just after a rising edge; returns just after the
    // edge that completes it.
    task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [5:0] a, input logic [31:0] wd);
        bit mis, st, ld;
        mis = is_mis(sz, a) && (rd || wr);
        st  = wr;
        ld  = rd && !wr;
        req_valid = 1'b1; req_rd = rd; req_wr = wr; req_size = sz;
        req_unsigned = uns; req_addr = {26'd0, a}; req_wdata = wd;
        #3;
        check("mem_addr", mem_addr, {26'd0, a[5:2], 2'b00});
        if (mis) begin
            check("mis_read", mem_read, 0); check("mis_write", mem_write, 0);
            check("mis_ready", req_ready, 1);
        end else if (st && sz[1]) begin
            check("sw_write", mem_write, 1); check("sw_read", mem_read, 0);
            check("sw_ready", req_ready, 1); check("sw_wdata", mem_wdata, wd);
        end else if (st) begin
            check("rmw_rd_read", mem_read, 1); check("rmw_rd_write", mem_write, 0);
            check("rmw_rd_ready", req_ready, 0);
        end else if (ld) begin
            check("ld_read", mem_read, 1); check("ld_write", mem_write, 0);
            check("ld_ready", req_ready, 1);
            exp_q.push_back(ref_load(sz, uns, a));
        end else begin
            check("nop_read", mem_read, 0); check("nop_write", mem_write, 0);
            check("nop_ready", req_ready, 1);
        end
        @(posedge clk); #1;
        check("align_err", align_err, {31'd0, mis});
        if (!mis && st) begin
            ref_store(sz, a, wd);
            if (!sz[1]) begin
                #3;
                check("rmw_wr_write", mem_write, 1); check("rmw_wr_read", mem_read, 0);
                check("rmw_wr_ready", req_ready, 1);
                check("rmw_wr_addr", mem_addr, {26'd0, a[5:2], 2'b00});
                check("rmw_wr_wdata", mem_wdata, ref_word(a));
                @(posedge clk); #1;
                check("rmw_align_err", align_err, 0);
            end
        end
    endtask

    task automatic idle();
        req_valid = 1'b0; req_rd = 1'b0; req_wr = 1'b0;
        #3;
        check("idle_ready", req_ready, 1);
        check("idle_read", mem_read, 0);
        check("idle_write", mem_write, 0);
        @(posedge clk); #1;
        check("idle_wb_valid", wb_valid, 0);
        check("idle_align_err", align_err, 0);
    endtask

    initial begin
        logic [31:0] w;
        for (int i = 0; i < 16; i++) begin
            w = (i == 0) ? 32'h00430822 : (i == 1) ? 32'h8CA40006 : $urandom;
            tb_mem[i] = w;
            ref_bytes[4*i]   = w[31:24];
            ref_bytes[4*i+1] = w[23:16];
            ref_bytes[4*i+2] = w[15:8];
            ref_bytes[4*i+3] = w[7:0];
        end

        // Reset held with an LW presented.
        rst_n = 1'b0;
        req_valid = 1'b1; req_rd = 1'b1; req_wr = 1'b0; req_size = 2'b10;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        #3;
        check("rst_wb_valid", wb_valid, 0); check("rst_wb_data", wb_data, 0);
        check("rst_align_err", align_err, 0); check("rst_ready", req_ready, 0);
        check("rst_read", mem_read, 0); check("rst_write", mem_write, 0);
        @(posedge clk); @(posedge clk); #3;
        check("rst_ready_hold", req_ready, 0);
        check("rst_read_hold", mem_read, 0);
        rst_n = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;

        // Directed sequence.
        idle();
        issue(1, 0, 2'b10, 0, 6'h00, 32'h0);          // LW 0x0
        idle();
        issue(1, 0, 2'b00, 0, 6'h04, 32'h0);          // LB 0x4
        issue(1, 0, 2'b00, 1, 6'h04, 32'h0);          // LBU 0x4
        issue(1, 0, 2'b01, 0, 6'h06, 32'h0);          // LH 0x6
        issue(1, 0, 2'b01, 1, 6'h04, 32'h0);          // LHU 0x4
        issue(0, 1, 2'b00, 0, 6'h01, 32'h123456FF);   // SB 0x1
        issue(1, 0, 2'b10, 0, 6'h00, 32'h0);          // LW 0x0
        issue(0, 1, 2'b01, 0, 6'h03, 32'hA5A5CAFE);   // SH 0x3
        issue(1, 0, 2'b10, 0, 6'h00, 32'h0);          // LW 0x0
        issue(1, 0, 2'b10, 0, 6'h02, 32'h0);          // LW 0x2
        issue(1, 1, 2'b10, 0, 6'h08, 32'hDEADBEEF);   // rd+wr: store wins
        issue(1, 0, 2'b10, 0, 6'h08, 32'h0);
        idle();
        idle();

        // Reset asserted while the RMW write is pending: store dropped.
        req_valid = 1'b1; req_rd = 1'b0; req_wr = 1'b1; req_size = 2'b01;
        req_unsigned = 1'b0; req_addr = 32'h2; req_wdata = 32'h0000BEEF;
        #3;
        check("rmwrst_read", mem_read, 1);
        check("rmwrst_ready", req_ready, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #3;
        check("rmwrst_write", mem_write, 0);
        check("rmwrst_ready_low", req_ready, 0);
        @(posedge clk); #3;
        rst_n = 1'b1; req_valid = 1'b0; req_wr = 1'b0;
        @(posedge clk); #1;
        check("rmwrst_wb_data", wb_data, 0);
        idle();
        issue(1, 0, 2'b10, 0, 6'h00, 32'h0);          // word 0x0 unchanged
        idle();

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            int kind;
            kind = $urandom_range(0, 5);
            if (kind == 0) idle();
            else issue(kind == 1 || kind == 2 || kind == 5, kind >= 3,
                       2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       6'($urandom_range(0, 63)), $urandom);
        end
        idle();
        idle();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
